// File: rtl/wb_regfile.sv
// Write-back select, 32 x XLEN integer register file (x0 hard-wired to zero) with two
// asynchronous read ports, plus a committed-write counter. Define REGFILE_BYPASS_EN for write-through reads.
module wb_regfile #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic             MemtoReg,
    input  logic [XLEN-1:0]  DataOut,
    input  logic [XLEN-1:0]  AluOut,
    input  logic [4:0]       Rd,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    output logic [XLEN-1:0]  ReadData1,
    output logic [XLEN-1:0]  ReadData2,
    output logic [XLEN-1:0]  WriteData,
    output logic [CNT_W-1:0] WbCount
);

    logic             commit;
    logic [XLEN-1:0]  rf_view [32];
    logic [CNT_W-1:0] wb_count_q;
    logic [CNT_W-1:0] wb_count_d;

    always_comb begin
        WriteData = MemtoReg ? DataOut : AluOut;
    end

    // A write to x0 is neither stored nor counted.
    assign commit = RegWrite && (Rd != 5'd0);

    assign rf_view[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [XLEN-1:0] reg_q;
            logic [XLEN-1:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (commit && (Rd == 5'(gi))) begin
                    reg_d = WriteData;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rf_view[gi] = reg_q;
        end
    endgenerate

    always_comb begin
        ReadData1 = rf_view[Rs1];
        ReadData2 = rf_view[Rs2];
`ifdef REGFILE_BYPASS_EN
        // While reset is held the write will be dropped, so it must not be forwarded either.
        if (reset && commit && (Rs1 == Rd)) begin
            ReadData1 = WriteData;
        end
        if (reset && commit && (Rs2 == Rd)) begin
            ReadData2 = WriteData;
        end
`endif
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (commit) begin
            wb_count_d = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign WbCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed pins from the test plan, then random traffic, all checked
// at each falling clock edge against an array-based model of the register file and counter.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic [63:0] DataOut;
    logic [63:0] AluOut;
    logic [4:0]  Rd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;

    logic [63:0] rd1, rd2, wd;
    logic [31:0] cnt;
    logic [63:0] rd1_4, rd2_4, wd_4;
    logic [3:0]  cnt_4;

    logic [63:0] model_regs [32];
    logic [31:0] model_cnt;

    int          tests = 0;
    int          fails = 0;

    logic        pin_en = 1'b0;
    int          pin_sel = 0;
    logic [63:0] pin_exp = '0;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .DataOut(DataOut), .AluOut(AluOut), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .ReadData1(rd1), .ReadData2(rd2), .WriteData(wd), .WbCount(cnt)
    );

    wb_regfile #(.XLEN(64), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .DataOut(DataOut), .AluOut(AluOut), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .ReadData1(rd1_4), .ReadData2(rd2_4), .WriteData(wd_4), .WbCount(cnt_4)
    );

    // Reference model: an array of registers and a plain write counter.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= '0;
            model_cnt <= '0;
        end else if (RegWrite && Rd != 5'd0) begin
            model_regs[Rd] <= MemtoReg ? DataOut : AluOut;
            model_cnt      <= model_cnt + 32'd1;
        end
    end

    function automatic logic [63:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
        if (BYP && reset && RegWrite && Rd != 5'd0 && rs == Rd)
            return MemtoReg ? DataOut : AluOut;
        return model_regs[rs];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("wdata",        wd,          MemtoReg ? DataOut : AluOut);
        chk("rdata1",       rd1,         exp_read(Rs1));
        chk("rdata2",       rd2,         exp_read(Rs2));
        chk("count",        64'(cnt),    64'(model_cnt));
        chk("rdata1_c4",    rd1_4,       exp_read(Rs1));
        chk("count_c4",     64'(cnt_4),  64'(model_cnt % 32'd16));
        if (pin_en) begin
            case (pin_sel)
                0: chk("pin_rdata1",   rd1,         pin_exp);
                1: chk("pin_rdata2",   rd2,         pin_exp);
                2: chk("pin_wdata",    wd,          pin_exp);
                3: chk("pin_count",    64'(cnt),    pin_exp);
                default: chk("pin_count_c4", 64'(cnt_4), pin_exp);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input int sel, input logic [63:0] exp);
        pin_sel = sel;
        pin_exp = exp;
        pin_en  = 1'b1;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [63:0] dout,
                         input logic [63:0] alu, input logic [4:0] rd);
        RegWrite = rw;
        MemtoReg = m2r;
        DataOut  = dout;
        AluOut   = alu;
        Rd       = rd;
    endtask

    initial begin
        reset = 1'b0;
        Rs1 = 5'd5;
        Rs2 = 5'd0;
        drive(1'b1, 1'b0, 64'd0, 64'hDEAD, 5'd5);
        repeat (3) tick();

        // Release reset; nothing written while it was held.
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'hDEAD, 5'd5);
        pin(0, 64'd0);
        tick();
        for (int r = 1; r < 32; r++) begin
            Rs1 = 5'(r);
            Rs2 = 5'(31 - r);
            pin(0, 64'd0);
            tick();
        end
        pin(3, 64'd0);
        tick();

        // ALU write to x3.
        drive(1'b1, 1'b0, 64'd0, 64'h0000_0000_1234_5678, 5'd3);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        Rs1 = 5'd3;
        pin(0, 64'h0000_0000_1234_5678);
        tick();
        pin(3, 64'd1);
        tick();

        // Load write to x31.
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd31);
        pin(2, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        Rs1 = 5'd31;
        pin(0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // x0 stays zero and is not counted.
        drive(1'b1, 1'b0, 64'd0, 64'hABCD, 5'd0);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        Rs1 = 5'd0;
        pin(0, 64'd0);
        tick();
        pin(3, 64'd2);
        tick();

        // Same-cycle read of a register being written.
        drive(1'b1, 1'b0, 64'd0, 64'h1, 5'd7);
        tick();
        drive(1'b1, 1'b0, 64'd0, 64'h2, 5'd7);
        Rs1 = 5'd7;
        Rs2 = 5'd7;
        pin(0, BYP ? 64'h2 : 64'h1);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        pin(1, 64'h2);
        tick();
        pin(3, 64'd4);
        tick();

        // Mid-cycle reset pulse while a write is pending.
        drive(1'b1, 1'b0, 64'd0, 64'h55, 5'd1);
        tick();
        drive(1'b1, 1'b0, 64'd0, 64'h66, 5'd1);
        Rs1 = 5'd1;
        #2 reset = 1'b0;
        #4 RegWrite = 1'b0;
        reset = 1'b1;
        tick();
        pin(3, 64'd0);
        tick();
        pin(0, 64'd0);
        tick();

        // 17 commits wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 64'd0, 64'(i + 1), 5'd1);
            tick();
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        pin(4, 64'd1);
        tick();
        pin(3, 64'd17);
        tick();
        pin(0, 64'd17);
        tick();

        // Random traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 3000; n++) begin
            RegWrite = ($urandom_range(0, 3) != 0);
            MemtoReg = 1'($urandom);
            DataOut  = {$urandom, $urandom};
            AluOut   = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0)
                Rd = 5'd0;
            else if ($urandom_range(0, 1) == 0)
                Rd = 5'($urandom_range(1, 6));
            else
                Rd = 5'($urandom);
            Rs1 = ($urandom_range(0, 2) == 0) ? Rd : 5'($urandom);
            Rs2 = ($urandom_range(0, 2) == 0) ? Rd : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
